// File: rtl/mul_cpa_resolver_pkg.sv
// Shared definitions for the Booth multiplier carry-propagate resolver:
// widths, chunking and the resolver state encoding.
package mul_pkg;

   localparam int MUL_WIDTH  = 64;
   localparam int MUL_CHUNK  = 16;
   localparam int NUM_CHUNKS = MUL_WIDTH / MUL_CHUNK;
   localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } cpa_state_t;

endpackage

// File: rtl/mul_cpa_resolver_if.sv
// Operand/result handshake bundle between the CSA tree, the resolver and writeback.
interface mul_cpa_resolver_if
   import mul_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_sum;
   logic [WIDTH-1:0] in_carry;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_product;
   logic             busy;

   modport slave (
      input  in_valid, in_sum, in_carry, out_ready,
      output in_ready, out_valid, out_product, busy
   );

   modport master (
      output in_valid, in_sum, in_carry, out_ready,
      input  in_ready, out_valid, out_product, busy
   );

endinterface

// File: rtl/mul_cpa_resolver_chunk.sv
// Narrow ripple adder slice reused by the resolver on every ADD cycle.
module cpa_chunk
   import mul_pkg::*;
#(
   parameter int CHUNK = MUL_CHUNK
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             cout
);

   logic [CHUNK:0] w_total;

   assign w_total   = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
   assign {cout, s} = w_total;

endmodule

// File: rtl/mul_cpa_resolver.sv
// Resolves the CSA tree's sum/carry vectors into one product, CHUNK bits per
// cycle through a single narrow adder with a registered carry between slices.
module mul_cpa_resolver
   import mul_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH,
   parameter int CHUNK = MUL_CHUNK
) (
   input logic               clk,
   input logic               reset_n,
   mul_cpa_resolver_if.slave bus
);

   localparam int N_CH = WIDTH / CHUNK;
   localparam int IW   = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(N_CH - 1);

   generate
      if (WIDTH % CHUNK != 0) begin : g_badChunk
         $error("mul_cpa_resolver: WIDTH must be a multiple of CHUNK");
      end
   endgenerate

   cpa_state_t       r_state;
   cpa_state_t       w_nextState;
   logic [WIDTH-1:0] r_opSum;
   logic [WIDTH-1:0] r_opCarry;
   logic [WIDTH-1:0] r_result;
   logic [IW-1:0]    r_idx;
   logic             r_carry;

   logic             w_inReady;
   logic             w_outValid;
   logic             w_busy;
   logic             w_capture;
   logic [31:0]      w_base;
   logic [CHUNK-1:0] w_sliceA;
   logic [CHUNK-1:0] w_sliceB;
   logic [CHUNK-1:0] w_chunkSum;
   logic             w_chunkCout;

   assign w_base   = 32'(r_idx) * 32'(CHUNK);
   assign w_sliceA = r_opSum[w_base +: CHUNK];
   assign w_sliceB = r_opCarry[w_base +: CHUNK];

   cpa_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a    (w_sliceA),
      .b    (w_sliceB),
      .cin  (r_carry),
      .s    (w_chunkSum),
      .cout (w_chunkCout)
   );

   // in_ready looks only at state and out_ready so upstream never sees a loop through in_valid
   always_comb begin
      w_nextState = r_state;
      w_inReady   = 1'b0;
      w_outValid  = 1'b0;
      w_busy      = 1'b0;
      unique case (r_state)
         IDLE: begin
            w_inReady = 1'b1;
            if (bus.in_valid) w_nextState = ADD;
         end
         ADD: begin
            w_busy = 1'b1;
            if (r_idx == LAST_IDX) w_nextState = DONE;
         end
         DONE: begin
            w_outValid = 1'b1;
            w_inReady  = bus.out_ready;
            if (bus.out_ready) w_nextState = bus.in_valid ? ADD : IDLE;
         end
         default: w_nextState = IDLE;
      endcase
   end

   assign w_capture = bus.in_valid & w_inReady;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= IDLE;
         r_opSum   <= '0;
         r_opCarry <= '0;
         r_result  <= '0;
         r_idx     <= '0;
         r_carry   <= 1'b0;
      end else begin
         r_state <= w_nextState;
         if (w_capture) begin
            r_opSum   <= bus.in_sum;
            r_opCarry <= bus.in_carry;
            r_idx     <= '0;
            r_carry   <= 1'b0;
         end else if (r_state == ADD) begin
            // The carry out of the top slice is simply dropped: result is modulo 2^WIDTH
            r_result[w_base +: CHUNK] <= w_chunkSum;
            r_carry                   <= w_chunkCout;
            r_idx                     <= r_idx + IW'(1);
         end
      end
   end

   assign bus.in_ready    = w_inReady;
   assign bus.out_valid   = w_outValid;
   assign bus.busy        = w_busy;
   assign bus.out_product = r_result;

endmodule
